// File: rtl/dut_out_packer.sv
// Packs 16-bit DUT samples into 32-bit AXI-Stream words with tlast framing, FIFO and overflow flag.
// Define DUT_PACKER_OVF_CNT_EN to add the saturating ovf_cnt dropped-word counter port.
module dut_out_packer #(
  parameter int DW         = 16,
  parameter int PKT_LEN    = 256,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DW-1:0]    s_data,
  input  logic             s_valid,
  output logic [31:0]      m_axis_tdata,
  output logic [3:0]       m_axis_tkeep,
  output logic             m_axis_tlast,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             busy,
  output logic             ovf,
  output logic [CNT_W-1:0] pkt_cnt
`ifdef DUT_PACKER_OVF_CNT_EN
  ,
  output logic [CNT_W-1:0] ovf_cnt
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [15:0] LAST = 16'(PKT_LEN - 1);

  logic [1:0]  state;
  logic [15:0] half_q;
  logic        half_v;
  logic [31:0] hold_d;
  logic        hold_l;
  logic        hold_v;
  logic [15:0] wcnt;

  logic        take;
  logic        push;
  logic [36:0] push_w;
  logic        wlast;

  logic [36:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        empty;
  logic        full;
  logic        pop;
  logic        wr_en;
  logic [36:0] head;

  assign take  = (state == RUN) && en && s_valid;
  assign wlast = (wcnt == LAST);

  // Held word is forced to close the packet only when no half sample follows it
  always_comb begin
    push   = 1'b0;
    push_w = '0;
    if (take && half_v && hold_v) begin
      push   = 1'b1;
      push_w = {hold_l, 4'hF, hold_d};
    end else if (state == FLUSH) begin
      if (hold_v) begin
        push   = 1'b1;
        push_w = {hold_l | ~half_v, 4'hF, hold_d};
      end else if (half_v) begin
        push   = 1'b1;
        push_w = {1'b1, 4'h3, 16'h0, half_q};
      end
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && m_axis_tready;
  assign wr_en = push && (!full || pop);
  assign head  = mem[rd_ptr[AW-1:0]];

  assign m_axis_tvalid = !empty;
  assign m_axis_tdata  = empty ? 32'h0 : head[31:0];
  assign m_axis_tkeep  = empty ? 4'h0 : head[35:32];
  assign m_axis_tlast  = !empty && head[36];
  assign busy          = (state != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_w;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      half_q  <= '0;
      half_v  <= 1'b0;
      hold_d  <= '0;
      hold_l  <= 1'b0;
      hold_v  <= 1'b0;
      wcnt    <= '0;
      ovf     <= 1'b0;
      pkt_cnt <= '0;
`ifdef DUT_PACKER_OVF_CNT_EN
      ovf_cnt <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (en) begin
            state   <= RUN;
            ovf     <= 1'b0;
            pkt_cnt <= '0;
            wcnt    <= '0;
            half_v  <= 1'b0;
            hold_v  <= 1'b0;
`ifdef DUT_PACKER_OVF_CNT_EN
            ovf_cnt <= '0;
`endif
          end
        end
        RUN: begin
          if (take) begin
            if (!half_v) begin
              half_q <= s_data;
              half_v <= 1'b1;
            end else begin
              half_v <= 1'b0;
              hold_v <= 1'b1;
              hold_d <= {s_data, half_q};
              hold_l <= wlast;
              wcnt   <= wlast ? 16'h0 : wcnt + 16'h1;
            end
          end
          if (!en) state <= FLUSH;
        end
        FLUSH: begin
          if (hold_v) hold_v <= 1'b0;
          else        half_v <= 1'b0;
          if (!hold_v || !half_v) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (push && push_w[36]) pkt_cnt <= pkt_cnt + CNT_W'(1);
      if (push && full && !pop) begin
        ovf <= 1'b1;
`ifdef DUT_PACKER_OVF_CNT_EN
        if (ovf_cnt != '1) ovf_cnt <= ovf_cnt + CNT_W'(1);
`endif
      end
    end
  end

endmodule

// File: tb/tb_dut_out_packer.sv
// Directed bench for dut_out_packer (PKT_LEN=4, FIFO_DEPTH=4).
// Covers packing, flush, overflow, stalls, async reset and re-arm in FLUSH.
module tb_dut_out_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        busy;
  logic        ovf;
  logic [15:0] pkt_cnt;
`ifdef DUT_PACKER_OVF_CNT_EN
  logic [15:0] ovf_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [36:0] q[$];
  logic        alt = 1'b0;
  logic        prev_stall = 1'b0;
  logic [36:0] prev_w = '0;

  dut_out_packer #(
    .DW(16), .PKT_LEN(4), .FIFO_DEPTH(4), .CNT_W(16)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .s_data(s_data), .s_valid(s_valid),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .busy(busy), .ovf(ovf), .pkt_cnt(pkt_cnt)
`ifdef DUT_PACKER_OVF_CNT_EN
    , .ovf_cnt(ovf_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [36:0] wd(input logic [31:0] d,
                                     input logic [3:0] k,
                                     input logic l);
    return {l, k, d};
  endfunction

  always @(posedge clk) begin
    if (alt) begin
      #1;
      m_axis_tready = ~m_axis_tready;
    end
  end

  // Collect popped words; during a stall the head must not move
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", m_axis_tvalid, 1);
        chk("stall_word", {m_axis_tlast, m_axis_tkeep, m_axis_tdata},
            prev_w);
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_w = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
      if (m_axis_tvalid && m_axis_tready)
        q.push_back({m_axis_tlast, m_axis_tkeep, m_axis_tdata});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d);
    s_data = d;
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
  endtask

  task automatic arm();
    en = 1'b1;
    step();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 200) begin
      step();
      n++;
    end
    chk(tag, busy, 0);
  endtask

  initial begin
    repeat (2) step();
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_pkt", pkt_cnt, 0);
    rst_n = 1'b1;
    step();

    // 1: one full packet
    arm();
    for (int i = 1; i <= 8; i++) send(16'(i));
    en = 1'b0;
    wait_idle("t1_idle");
    chk("t1_n", q.size(), 4);
    chk("t1_w0", q[0], wd(32'h00020001, 4'hF, 0));
    chk("t1_w1", q[1], wd(32'h00040003, 4'hF, 0));
    chk("t1_w2", q[2], wd(32'h00060005, 4'hF, 0));
    chk("t1_w3", q[3], wd(32'h00080007, 4'hF, 1));
    chk("t1_pkt", pkt_cnt, 1);
    chk("t1_ovf", ovf, 0);
    q.delete();

    // 2: odd sample count flushes a half word
    arm();
    for (int i = 1; i <= 3; i++) send(16'(i));
    en = 1'b0;
    wait_idle("t2_idle");
    chk("t2_n", q.size(), 2);
    chk("t2_w0", q[0], wd(32'h00020001, 4'hF, 0));
    chk("t2_w1", q[1], wd(32'h00000003, 4'h3, 1));
    chk("t2_pkt", pkt_cnt, 1);
    q.delete();

    // 3: overflow with sink stalled
    m_axis_tready = 1'b0;
    arm();
    for (int i = 1; i <= 12; i++) send(16'(i));
    en = 1'b0;
    repeat (4) step();
    chk("t3_ovf", ovf, 1);
`ifdef DUT_PACKER_OVF_CNT_EN
    chk("t3_ovfcnt", ovf_cnt, 2);
`endif
    chk("t3_busy", busy, 1);
    m_axis_tready = 1'b1;
    wait_idle("t3_idle");
    chk("t3_n", q.size(), 4);
    chk("t3_w0", q[0], wd(32'h00020001, 4'hF, 0));
    chk("t3_w1", q[1], wd(32'h00040003, 4'hF, 0));
    chk("t3_w2", q[2], wd(32'h00060005, 4'hF, 0));
    chk("t3_w3", q[3], wd(32'h00080007, 4'hF, 1));
    q.delete();

    // 4: alternating tready, continuous input
    arm();
    alt = 1'b1;
    for (int i = 1; i <= 16; i++) send(16'(i));
    en = 1'b0;
    repeat (4) step();
    alt = 1'b0;
    step();
    m_axis_tready = 1'b1;
    wait_idle("t4_idle");
    chk("t4_n", q.size(), 8);
    for (int k = 0; k < 8; k++)
      chk($sformatf("t4_w%0d", k), q[k],
          wd({16'(2 * k + 2), 16'(2 * k + 1)}, 4'hF, (k % 4) == 3));
    chk("t4_ovf", ovf, 0);
    chk("t4_pkt", pkt_cnt, 2);
    q.delete();

    // 5: asynchronous reset mid-packet
    m_axis_tready = 1'b0;
    arm();
    for (int i = 1; i <= 5; i++) send(16'(i));
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_tvalid", m_axis_tvalid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_pkt", pkt_cnt, 0);
    en = 1'b0;
    m_axis_tready = 1'b1;
    step();
    #3;
    rst_n = 1'b1;
    step();
    q.delete();
    arm();
    chk("t5_pkt_arm", pkt_cnt, 0);
    send(16'hAAAA);
    send(16'hBBBB);
    en = 1'b0;
    wait_idle("t5_idle");
    chk("t5_n", q.size(), 1);
    chk("t5_w0", q[0], wd(32'hBBBBAAAA, 4'hF, 1));
    chk("t5_pkt_end", pkt_cnt, 1);
    q.delete();

    // 6: en re-raised inside FLUSH is ignored
    m_axis_tready = 1'b0;
    arm();
    for (int i = 1; i <= 13; i++) send(16'(i));
    en = 1'b0;
    step();
    en = 1'b1;
    step();
    en = 1'b0;
    step();
    chk("t6_ovf_kept", ovf, 1);
`ifdef DUT_PACKER_OVF_CNT_EN
    chk("t6_ovfcnt", ovf_cnt, 3);
`endif
    m_axis_tready = 1'b1;
    wait_idle("t6_drain");
    chk("t6_n_old", q.size(), 4);
    q.delete();
    arm();
    chk("t6_ovf_clr", ovf, 0);
    chk("t6_pkt_clr", pkt_cnt, 0);
`ifdef DUT_PACKER_OVF_CNT_EN
    chk("t6_ovfcnt_clr", ovf_cnt, 0);
`endif
    for (int i = 1; i <= 4; i++) send(16'(16'h10 + i));
    en = 1'b0;
    wait_idle("t6_idle");
    chk("t6_n", q.size(), 2);
    chk("t6_w0", q[0], wd(32'h00120011, 4'hF, 0));
    chk("t6_w1", q[1], wd(32'h00140013, 4'hF, 1));
    chk("t6_ovf", ovf, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
